mux_feed_ctrl: RTL and testbench



---
 rtl/mux_feed_ctrl.sv | 159 +++++++++++++++
 tb/tb_mux_feed_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mux_feed_ctrl.sv
// mux_feed_ctrl: sequences the column selects of the 4:1 row-mux bank that
// feeds 4x4 operand matrices into the matmul array, using a diagonal skew.
// A start request runs FEED (2*N_ROWS-1 cycles), then DRAIN (DRAIN_CYC
// cycles), then a one-cycle DONE. This block never touches data.
//
// Optional feature: define MUX_FEED_CTRL_JOBCNT_EN to build the completed-job
// counter. Without it, job_count is tied to 0 and the port list is unchanged.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   job request, sampled only in IDLE
//   abort      in   synchronous cancel of a FEED/DRAIN job
//   sel        out  packed mux selects, sel[2r+1:2r] = column index of row r
//   mux_reset  out  bit r forces the row-r mux output to zero
//   busy       out  high whenever state != IDLE
//   done       out  one-cycle completion pulse
//   job_count  out  completed jobs, wraps (0 when the feature is compiled out)
module mux_feed_ctrl #(
  parameter int unsigned N_ROWS    = 4,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [2*N_ROWS-1:0]   sel,
  output logic [N_ROWS-1:0]     mux_reset,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      job_count
);

  localparam int unsigned FEED_LEN = 2 * N_ROWS - 1;
  localparam int unsigned T_MAX    = (FEED_LEN > DRAIN_CYC) ? FEED_LEN : DRAIN_CYC;
  localparam int unsigned T_W      = $clog2(T_MAX + 1);
  localparam int unsigned R_W      = $clog2(N_ROWS);
  localparam int unsigned S_W      = $clog2(2 * N_ROWS);
  localparam logic [T_W-1:0] LAST_FEED  = T_W'(FEED_LEN - 1);
  localparam logic [T_W-1:0] LAST_DRAIN = T_W'((DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [T_W-1:0]        t_q, t_d;
  logic [2*N_ROWS-1:0]   sel_q, sel_d;
  logic [N_ROWS-1:0]     mux_reset_q, mux_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next state, plus outputs decoded from the next state so they can be
  // registered without adding a cycle of latency.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    sel_d       = '0;
    mux_reset_d = '1;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_FEED;
          t_d     = '0;
        end
      end
      S_FEED: begin
        if (abort) begin
          state_d = S_IDLE;
          t_d     = '0;
        end else if (t_q == LAST_FEED) begin
          state_d = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          t_d     = '0;
        end else if (t_q == LAST_DRAIN) begin
          state_d = S_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    // Diagonal skew: row r is live for t in [r, r+3] and selects column t-r.
    if (state_d == S_FEED) begin
      for (int unsigned r = 0; r < N_ROWS; r++) begin
        if ((t_d >= T_W'(r)) && (t_d <= T_W'(r + 3))) begin
          sel_d[S_W'(2 * r) +: 2] = 2'(t_d - T_W'(r));
          mux_reset_d[R_W'(r)]    = 1'b0;
        end
      end
    end
  end

  // State, phase counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      sel_q       <= '0;
      mux_reset_q <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      sel_q       <= sel_d;
      mux_reset_q <= mux_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sel       = sel_q;
  assign mux_reset = mux_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef MUX_FEED_CTRL_JOBCNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts on leaving DONE; aborted or reset jobs never reach DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_DONE) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign job_count = cnt_q;
`else
  assign job_count = '0;
`endif

endmodule

// File: tb/tb_mux_feed_ctrl.sv
// Scoreboard bench for mux_feed_ctrl: a default instance (DRAIN_CYC=4) and a
// DRAIN_CYC=0 instance. Stimulus pushes hand-computed expected outputs tagged
// with the cycle they apply to; a negedge monitor pops and compares.
module tb_mux_feed_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, abort1, start0, abort0;

  logic [7:0]  sel1, sel0;
  logic [3:0]  mr1, mr0;
  logic        busy1, busy0, done1, done0;
  logic [15:0] jc1, jc0;

  mux_feed_ctrl #(.N_ROWS(4), .DRAIN_CYC(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .sel(sel1), .mux_reset(mr1), .busy(busy1), .done(done1), .job_count(jc1)
  );

  mux_feed_ctrl #(.N_ROWS(4), .DRAIN_CYC(0), .CNT_W(16)) dut_nodrain (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .sel(sel0), .mux_reset(mr0), .busy(busy0), .done(done0), .job_count(jc0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          id;
    string       name;
    logic [7:0]  sel;
    logic [3:0]  mr;
    logic        busy;
    logic        done;
    logic [15:0] jc;
  } exp_t;

  exp_t sb[$];
  int   cur_cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // Hand-derived FEED outputs for t = 0..6 ({sel_r3,sel_r2,sel_r1,sel_r0}).
  logic [7:0] sel_tab [7] = '{8'h00, 8'h01, 8'h06, 8'h1B, 8'h6C, 8'hB0, 8'hC0};
  logic [3:0] mr_tab  [7] = '{4'hE, 4'hC, 4'h8, 4'h0, 4'h1, 4'h3, 4'h7};

  always @(posedge clk) cur_cyc <= cur_cyc + 1;

  function automatic logic [15:0] jcv(input int n);
`ifdef MUX_FEED_CTRL_JOBCNT_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  // Drive one cycle of inputs for instance id and queue the response
  // expected after the next edge.
  task automatic step(input int id, input logic st, input logic ab, input logic rn,
                      input string name, input logic [7:0] e_sel, input logic [3:0] e_mr,
                      input logic e_busy, input logic e_done, input logic [15:0] e_jc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n  = rn;
    start1 = (id == 1) ? st : 1'b0;
    abort1 = (id == 1) ? ab : 1'b0;
    start0 = (id == 0) ? st : 1'b0;
    abort0 = (id == 0) ? ab : 1'b0;
    e.cyc = cur_cyc + 1; e.id = id; e.name = name;
    e.sel = e_sel; e.mr = e_mr; e.busy = e_busy; e.done = e_done; e.jc = e_jc;
    sb.push_back(e);
  endtask

  task automatic step_idle(input int id, input logic st, input logic ab, input logic rn,
                           input string name, input int jc);
    step(id, st, ab, rn, name, 8'h00, 4'hF, 1'b0, 1'b0, jcv(jc));
  endtask

  // Expected output at position idx of a job (0 = first FEED cycle).
  task automatic step_job(input int id, input logic st, input logic ab, input int idx,
                          input int drain, input int jc);
    if (idx < 7)
      step(id, st, ab, 1'b1, $sformatf("feed_t%0d", idx), sel_tab[idx], mr_tab[idx],
           1'b1, 1'b0, jcv(jc));
    else if (idx < 7 + drain)
      step(id, st, ab, 1'b1, $sformatf("drain_i%0d", idx), 8'h00, 4'hF, 1'b1, 1'b0, jcv(jc));
    else
      step(id, st, ab, 1'b1, $sformatf("done_i%0d", idx), 8'h00, 4'hF, 1'b1, 1'b1, jcv(jc));
  endtask

  // Monitor: compare every queued expectation in the cycle it applies to.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cur_cyc) begin
      exp_t e;
      logic [29:0] act, req;
      e = sb.pop_front();
      act = (e.id == 0) ? {sel0, mr0, busy0, done0, jc0} : {sel1, mr1, busy1, done1, jc1};
      req = {e.sel, e.mr, e.busy, e.done, e.jc};
      vectors++;
      if (e.cyc != cur_cyc || act !== req) begin
        miscompares++;
        $display("FAIL %s dut%0d cyc%0d: got sel=%h mr=%h busy=%b done=%b jc=%0d, want sel=%h mr=%h busy=%b done=%b jc=%0d",
                 e.name, e.id, cur_cyc, act[29:22], act[21:18], act[17], act[16], act[15:0],
                 e.sel, e.mr, e.busy, e.done, e.jc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; start0 = 1'b0; abort0 = 1'b0;

    // Reset held for two edges, then release to idle.
    step_idle(1, 1'b0, 1'b0, 1'b0, "reset0", 0);
    step_idle(1, 1'b0, 1'b0, 1'b0, "reset1", 0);
    step_idle(1, 1'b0, 1'b0, 1'b1, "idle_after_reset", 0);

    // Single job: done at index 11, counter increments after DONE.
    step_job(1, 1'b1, 1'b0, 0, 4, 0);
    for (int i = 1; i < 12; i++) step_job(1, 1'b0, 1'b0, i, 4, 0);
    step_idle(1, 1'b0, 1'b0, 1'b1, "idle_after_job1", 1);

    // start held high: three jobs separated by exactly one IDLE cycle.
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 12; i++) step_job(1, 1'b1, 1'b0, i, 4, 1 + j);
      step_idle(1, 1'b1, 1'b0, 1'b1, $sformatf("b2b_gap%0d", j), 2 + j);
    end
    step_idle(1, 1'b0, 1'b0, 1'b1, "b2b_end", 4);

    // Abort at FEED t=4: idle next cycle, no done, count unchanged.
    step_job(1, 1'b1, 1'b0, 0, 4, 4);
    for (int i = 1; i < 5; i++) step_job(1, 1'b0, 1'b0, i, 4, 4);
    step_idle(1, 1'b0, 1'b1, 1'b1, "abort_feed", 4);
    step_idle(1, 1'b0, 1'b0, 1'b1, "after_abort", 4);
    step_idle(1, 1'b1, 1'b1, 1'b1, "start_abort_idle", 4);
    step_idle(1, 1'b0, 1'b0, 1'b1, "still_idle", 4);

    // Reset during the second DRAIN cycle, then a clean job.
    step_job(1, 1'b1, 1'b0, 0, 4, 4);
    for (int i = 1; i < 9; i++) step_job(1, 1'b0, 1'b0, i, 4, 4);
    step_idle(1, 1'b0, 1'b0, 1'b0, "reset_mid_drain", 0);
    step_idle(1, 1'b0, 1'b0, 1'b1, "idle_after_mid_reset", 0);
    step_job(1, 1'b1, 1'b0, 0, 4, 0);
    for (int i = 1; i < 12; i++) step_job(1, 1'b0, 1'b0, i, 4, 0);
    step_idle(1, 1'b0, 1'b0, 1'b1, "idle_after_rerun", 1);

    // DRAIN_CYC=0 instance: done at index 7.
    step_job(0, 1'b1, 1'b0, 0, 0, 0);
    for (int i = 1; i < 8; i++) step_job(0, 1'b0, 1'b0, i, 0, 0);
    step_idle(0, 1'b0, 1'b0, 1'b1, "nodrain_idle", 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
